// File: rtl/alu.sv
// alu: registered 4-bit ALU giving an 8-bit result, a carry/borrow/shift-out/div-by-zero flag and a division remainder
module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] opcode,
  output logic [7:0] result,
  output logic       carry_out,
  output logic [3:0] remainder
);
  logic [7:0] r_n;
  logic       c_n;
  logic [3:0] m_n;
  always_comb begin
    r_n = '0;
    c_n = 1'b0;
    m_n = '0;
    case (opcode)
      4'h0: {c_n, r_n[3:0]} = {1'b0, A} + {1'b0, B};
      4'h1: begin
        r_n[3:0] = A - B;
        c_n = A < B;
      end
      4'h2: r_n = {4'h0, A} * {4'h0, B};
      4'h3: begin
        // a zero divisor flags an error and passes A through as the remainder
        r_n[3:0] = (B == 4'h0) ? 4'h0 : A / B;
        m_n = (B == 4'h0) ? A : A % B;
        c_n = B == 4'h0;
      end
      4'h4: r_n[3:0] = A & B;
      4'h5: r_n[3:0] = A | B;
      4'h6: r_n[3:0] = ~A;
      4'h7: r_n[3:0] = A ^ B;
      4'hb: {c_n, r_n[3:0]} = {A, 1'b0};
      4'hc: {r_n[3:0], c_n} = {1'b0, A};
      4'hd: r_n[0] = ~A[0];
      4'he: r_n[0] = ~(A[0] & B[0]);
      4'hf: r_n[0] = ~(A[0] | B[0]);
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      result <= '0;
      carry_out <= 1'b0;
      remainder <= '0;
    end else begin
      result <= r_n;
      carry_out <= c_n;
      remainder <= m_n;
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu
module tb_alu;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic [3:0] opcode = '0;
  logic [7:0] result;
  logic       carry_out;
  logic [3:0] remainder;
  int compared = 0;
  int mismatched = 0;

  alu dut (
    .clk(clk),
    .rst_n(rst_n),
    .A(A),
    .B(B),
    .opcode(opcode),
    .result(result),
    .carry_out(carry_out),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] er, input logic ec, input logic [3:0] em);
    compared++;
    assert ({result, carry_out, remainder} === {er, ec, em}) else begin
      mismatched++;
      $error("FAIL %s: observed r=%h c=%b m=%h expected r=%h c=%b m=%h",
             tag, result, carry_out, remainder, er, ec, em);
    end
  endtask

  task automatic run(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                     input logic [7:0] er, input logic ec, input logic [3:0] em);
    @(negedge clk);
    A = a;
    B = b;
    opcode = op;
    @(posedge clk);
    #1;
    chk(tag, er, ec, em);
  endtask

  initial begin
    #12;
    chk("reset_hold", 8'h00, 1'b0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run("add_15_15", 4'hf, 4'hf, 4'h0, 8'h0e, 1'b1, 4'h0);
    run("div_by_zero_pre", 4'h9, 4'h0, 4'h3, 8'h00, 1'b1, 4'h9);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 8'h00, 1'b0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run("add_5_3", 4'h5, 4'h3, 4'h0, 8'h08, 1'b0, 4'h0);
    run("add_15_1", 4'hf, 4'h1, 4'h0, 8'h00, 1'b1, 4'h0);
    run("sub_6_2", 4'h6, 4'h2, 4'h1, 8'h04, 1'b0, 4'h0);
    run("sub_3_5", 4'h3, 4'h5, 4'h1, 8'h0e, 1'b1, 4'h0);
    run("sub_0_1", 4'h0, 4'h1, 4'h1, 8'h0f, 1'b1, 4'h0);
    run("mul_4_5", 4'h4, 4'h5, 4'h2, 8'h14, 1'b0, 4'h0);
    run("mul_15_15", 4'hf, 4'hf, 4'h2, 8'he1, 1'b0, 4'h0);
    run("div_8_2", 4'h8, 4'h2, 4'h3, 8'h04, 1'b0, 4'h0);
    run("div_7_2", 4'h7, 4'h2, 4'h3, 8'h03, 1'b0, 4'h1);
    run("div_9_0", 4'h9, 4'h0, 4'h3, 8'h00, 1'b1, 4'h9);
    run("and", 4'ha, 4'hc, 4'h4, 8'h08, 1'b0, 4'h0);
    run("or", 4'ha, 4'hc, 4'h5, 8'h0e, 1'b0, 4'h0);
    run("xor", 4'ha, 4'hc, 4'h7, 8'h06, 1'b0, 4'h0);
    run("not", 4'ha, 4'hc, 4'h6, 8'h05, 1'b0, 4'h0);
    run("rsv_1001", 4'hf, 4'hf, 4'h9, 8'h00, 1'b0, 4'h0);
    run("rsv_1000", 4'hf, 4'hf, 4'h8, 8'h00, 1'b0, 4'h0);
    run("rsv_1010", 4'hf, 4'h0, 4'ha, 8'h00, 1'b0, 4'h0);
    run("shl_1001", 4'h9, 4'h0, 4'hb, 8'h02, 1'b1, 4'h0);
    run("shl_0111", 4'h7, 4'h0, 4'hb, 8'h0e, 1'b0, 4'h0);
    run("shr_1001", 4'h9, 4'h0, 4'hc, 8'h04, 1'b1, 4'h0);
    run("shr_0110", 4'h6, 4'h0, 4'hc, 8'h03, 1'b0, 4'h0);
    run("shl_1001_b3", 4'h9, 4'h3, 4'hb, 8'h02, 1'b1, 4'h0);
    run("shl_0111_b3", 4'h7, 4'h3, 4'hb, 8'h0e, 1'b0, 4'h0);
    run("shr_1001_b3", 4'h9, 4'h3, 4'hc, 8'h04, 1'b1, 4'h0);
    run("shr_0110_b3", 4'h6, 4'h3, 4'hc, 8'h03, 1'b0, 4'h0);
    run("bnot_1", 4'h1, 4'h0, 4'hd, 8'h00, 1'b0, 4'h0);
    run("bnot_0", 4'h0, 4'h0, 4'hd, 8'h01, 1'b0, 4'h0);
    run("bnand_1_3", 4'h1, 4'h3, 4'he, 8'h00, 1'b0, 4'h0);
    run("bnand_0_1", 4'h0, 4'h1, 4'he, 8'h01, 1'b0, 4'h0);
    run("bnor_a_c", 4'ha, 4'hc, 4'hf, 8'h01, 1'b0, 4'h0);
    run("bnor_1_0", 4'h1, 4'h0, 4'hf, 8'h00, 1'b0, 4'h0);
    run("mul_hold_pre", 4'hf, 4'hf, 4'h2, 8'he1, 1'b0, 4'h0);
    #2;
    A = 4'h1;
    B = 4'h2;
    opcode = 4'h0;
    #1;
    chk("hold_between_edges", 8'he1, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    chk("hold_next_edge", 8'h03, 1'b0, 4'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
